// File: rtl/iob_reset_sequencer_pkg.sv
// Shared state encoding and counter sizing for the reset sequencer.
// The counter width is derived from the largest programmable interval.
package iob_reset_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_ASSERT   = 2'd0,
    ST_WAIT_RDY = 2'd1,
    ST_RELEASE  = 2'd2,
    ST_RUN      = 2'd3
  } seq_state_e;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Wide enough to hold the largest interval itself, so saturating compares never wrap.
  function automatic int calc_cnt_w(input int min_assert, input int start,
                                    input int gap, input int timeout);
    return $clog2(max_of4(min_assert, start, gap, timeout) + 1);
  endfunction

endpackage

// File: rtl/iob_sync.sv
// Two-flop synchroniser for a vector of independent asynchronous levels.
// Each bit is synchronised on its own; there is no cross-bit coherency.
module iob_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_reg;
  logic [W-1:0] sync_reg;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        meta_reg[gi] <= 1'b0;
        sync_reg[gi] <= 1'b0;
      end else begin
        meta_reg[gi] <= d[gi];
        sync_reg[gi] <= meta_reg[gi];
      end
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/iob_reset_sequencer.sv
// Holds N_CH resets asserted, waits for every ready input to be stable, then
// drops the resets in index order GAP cycles apart; re-asserts all on restart or loss.
module iob_reset_sequencer
  import iob_reset_sequencer_pkg::*;
#(
  parameter int N_CH         = 3,
  parameter int N_RDY        = 2,
  parameter int MIN_ASSERT   = 16,
  parameter int START        = 5,
  parameter int GAP          = 10,
  parameter int TIMEOUT      = 0,
  parameter int LOSS_RESTART = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             restart,
  input  logic [N_RDY-1:0] rdy_i,
  output logic [N_CH-1:0]  rst_o,
  output logic             done_o,
  output logic             timeout_o
);

  localparam int CNT_W = calc_cnt_w(MIN_ASSERT, START, GAP, TIMEOUT);
  localparam int K_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [CNT_W-1:0] ASSERT_LAST = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START - 1);
  localparam logic [CNT_W-1:0] GAP_LAST    = CNT_W'(GAP - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CNT_W-1:0] TMO_FULL    = CNT_W'(TIMEOUT);
  localparam logic [K_W-1:0]   K_LAST      = K_W'(N_CH - 1);
  localparam logic [K_W-1:0]   K_FIRST     = K_W'((N_CH > 1) ? 1 : 0);
  localparam bit               TMO_EN      = (TIMEOUT != 0);
  localparam bit               LOSS_EN     = (LOSS_RESTART != 0);

  seq_state_e        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [CNT_W-1:0]  tcnt_reg;
  logic [K_W-1:0]    k_reg;
  logic [N_CH-1:0]   rst_reg;
  logic              done_reg;
  logic              timeout_reg;

  logic [N_RDY-1:0]  rdy_sync;
  logic              all_rdy;
  logic              in_release_run;
  logic              ready_lost;
  logic [N_CH-1:0]   chan_sel;

  iob_sync #(
    .W(N_RDY)
  ) u_rdy_sync (
    .clk (clk),
    .rstn(rstn),
    .d   (rdy_i),
    .q   (rdy_sync)
  );

  assign all_rdy        = &rdy_sync;
  assign in_release_run = (state_reg == ST_RELEASE) || (state_reg == ST_RUN);
  assign ready_lost     = LOSS_EN && in_release_run && !all_rdy;

  // One-hot mask of the channel the release phase drops next.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_sel
    assign chan_sel[gi] = (k_reg == K_W'(gi));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg   <= ST_ASSERT;
      cnt_reg     <= '0;
      tcnt_reg    <= '0;
      k_reg       <= K_FIRST;
      rst_reg     <= '1;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else if (restart) begin
      state_reg   <= ST_ASSERT;
      cnt_reg     <= '0;
      tcnt_reg    <= '0;
      k_reg       <= K_FIRST;
      rst_reg     <= '1;
      done_reg    <= 1'b0;
      timeout_reg <= 1'b0;
    end else if (ready_lost) begin
      // Same as restart, but the timeout history survives for software to inspect.
      state_reg   <= ST_ASSERT;
      cnt_reg     <= '0;
      tcnt_reg    <= '0;
      k_reg       <= K_FIRST;
      rst_reg     <= '1;
      done_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_ASSERT: begin
          if (cnt_reg == ASSERT_LAST) begin
            state_reg <= ST_WAIT_RDY;
            cnt_reg   <= '0;
            tcnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_WAIT_RDY: begin
          if (TMO_EN && (tcnt_reg != TMO_FULL)) begin
            tcnt_reg <= tcnt_reg + CNT_W'(1);
            if (tcnt_reg == TMO_LAST) timeout_reg <= 1'b1;
          end
          if (!all_rdy) begin
            cnt_reg <= '0;
          end else if (cnt_reg == START_LAST) begin
            cnt_reg    <= '0;
            k_reg      <= K_FIRST;
            rst_reg[0] <= 1'b0;
            if (N_CH == 1) begin
              state_reg <= ST_RUN;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_RELEASE;
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_reg == GAP_LAST) begin
            cnt_reg <= '0;
            rst_reg <= rst_reg & ~chan_sel;
            if (k_reg == K_LAST) begin
              state_reg <= ST_RUN;
              done_reg  <= 1'b1;
            end else begin
              k_reg <= k_reg + K_W'(1);
            end
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
        ST_RUN: begin
          state_reg <= ST_RUN;
        end
        default: begin
          state_reg <= ST_ASSERT;
        end
      endcase
    end
  end

  assign rst_o     = rst_reg;
  assign done_o    = done_reg;
  assign timeout_o = timeout_reg;

endmodule

// File: tb/tb_iob_reset_sequencer.sv
// Scoreboard bench for iob_reset_sequencer: four configurations run side by side
// against a release-time model, plus directed checks at the documented edges.
module tb_iob_reset_sequencer;

  localparam int NI = 4;
  localparam int MA = 16;
  localparam int ST = 5;
  localparam int GP = 10;
  localparam int NCH  [NI] = '{3, 3, 3, 1};
  localparam int TMO  [NI] = '{0, 20, 0, 0};
  localparam int LOSS [NI] = '{1, 1, 0, 1};

  logic       clk = 1'b0;
  logic       rstn;
  logic       restart_v [NI];
  logic [1:0] rdy_v     [NI];

  logic [2:0] rst0, rst1, rst2;
  logic       rst3;
  logic       done0, done1, done2, done3;
  logic       tmo0, tmo1, tmo2, tmo3;
  logic [4:0] act [NI];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  iob_reset_sequencer #(.N_CH(3), .N_RDY(2), .MIN_ASSERT(MA), .START(ST), .GAP(GP),
                        .TIMEOUT(0), .LOSS_RESTART(1)) u_dut0 (
    .clk(clk), .rstn(rstn), .restart(restart_v[0]), .rdy_i(rdy_v[0]),
    .rst_o(rst0), .done_o(done0), .timeout_o(tmo0));

  iob_reset_sequencer #(.N_CH(3), .N_RDY(2), .MIN_ASSERT(MA), .START(ST), .GAP(GP),
                        .TIMEOUT(20), .LOSS_RESTART(1)) u_dut1 (
    .clk(clk), .rstn(rstn), .restart(restart_v[1]), .rdy_i(rdy_v[1]),
    .rst_o(rst1), .done_o(done1), .timeout_o(tmo1));

  iob_reset_sequencer #(.N_CH(3), .N_RDY(2), .MIN_ASSERT(MA), .START(ST), .GAP(GP),
                        .TIMEOUT(0), .LOSS_RESTART(0)) u_dut2 (
    .clk(clk), .rstn(rstn), .restart(restart_v[2]), .rdy_i(rdy_v[2]),
    .rst_o(rst2), .done_o(done2), .timeout_o(tmo2));

  iob_reset_sequencer #(.N_CH(1), .N_RDY(2), .MIN_ASSERT(MA), .START(ST), .GAP(GP),
                        .TIMEOUT(0), .LOSS_RESTART(1)) u_dut3 (
    .clk(clk), .rstn(rstn), .restart(restart_v[3]), .rdy_i(rdy_v[3]),
    .rst_o(rst3), .done_o(done3), .timeout_o(tmo3));

  assign act[0] = {rst0, done0, tmo0};
  assign act[1] = {rst1, done1, tmo1};
  assign act[2] = {rst2, done2, tmo2};
  assign act[3] = {2'b00, rst3, done3, tmo3};

  // Model: absolute edge of the first release (r0) within the current epoch
  // (last reset/restart/loss); every output follows from r0 by arithmetic.
  typedef struct {
    int         e;
    int         epoch;
    int         r0;
    int         run;
    bit         tmo;
    logic [1:0] p0;
    logic [1:0] p1;
  } mdl_t;

  mdl_t       m [NI];
  logic [19:0] exp_q [$];

  task automatic model_reset(input int i);
    m[i].e = 0; m[i].epoch = 0; m[i].r0 = -1; m[i].run = 0;
    m[i].tmo = 1'b0; m[i].p0 = 2'b00; m[i].p1 = 2'b00;
  endtask

  task automatic model_edge(input int i, input logic rs, input logic [1:0] rdy);
    logic [1:0] seen;
    int         w;
    seen    = m[i].p1;           // value driven two edges earlier
    m[i].p1 = m[i].p0;
    m[i].p0 = rdy;
    m[i].e++;
    w = m[i].epoch + MA;
    if (rs) begin
      m[i].epoch = m[i].e; m[i].r0 = -1; m[i].run = 0; m[i].tmo = 1'b0;
    end else if (LOSS[i] != 0 && m[i].r0 >= 0 && seen != 2'b11) begin
      m[i].epoch = m[i].e; m[i].r0 = -1; m[i].run = 0;
    end else if (m[i].r0 < 0 && m[i].e > w) begin
      m[i].run = (seen == 2'b11) ? m[i].run + 1 : 0;
      if (m[i].run == ST) m[i].r0 = m[i].e;
      if (TMO[i] != 0 && m[i].e == w + TMO[i]) m[i].tmo = 1'b1;
    end
  endtask

  function automatic logic [4:0] expect_out(input int i);
    logic [2:0] r;
    logic       d;
    r = 3'b000;
    for (int k = 0; k < NCH[i]; k++)
      r[k] = !(m[i].r0 >= 0 && m[i].e >= m[i].r0 + k * GP);
    d = (m[i].r0 >= 0) && (m[i].e >= m[i].r0 + (NCH[i] - 1) * GP);
    return {r, d, m[i].tmo};
  endfunction

  // Advance the models over the coming edge, queue their expectation, wait for the next negedge.
  task automatic step();
    logic [19:0] w;
    w = '0;
    for (int i = 0; i < NI; i++) begin
      if (!rstn) model_reset(i);
      else model_edge(i, restart_v[i], rdy_v[i]);
      w[i*5 +: 5] = expect_out(i);
    end
    exp_q.push_back(w);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got {rst,done,timeout}=%b required %b", name, got, want);
    end
  endtask

  // Monitor: pops one expectation per clock edge and compares every instance.
  initial begin
    logic [19:0] w;
    logic [4:0]  prev [NI];
    for (int i = 0; i < NI; i++) prev[i] = 5'b11111;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard: no expectation queued at time %0t", $time);
      end else begin
        w = exp_q.pop_front();
        for (int i = 0; i < NI; i++) begin
          n_tests++;
          if (act[i] !== w[i*5 +: 5]) begin
            n_fail++;
            $display("FAIL dut%0d cycle edge %0d: got {rst,done,timeout}=%b required %b",
                     i, m[i].e, act[i], w[i*5 +: 5]);
          end
          if (act[i] !== prev[i])
            $display("[TB] dut%0d edge %0d rst_o=%b done_o=%b timeout_o=%b",
                     i, m[i].e, act[i][4:2], act[i][1], act[i][0]);
          prev[i] = act[i];
        end
      end
    end
  end

  initial begin
    int outage [NI];
    rstn = 1'b0;
    for (int i = 0; i < NI; i++) begin
      restart_v[i] = 1'b0;
      rdy_v[i]     = 2'b00;
      outage[i]    = 0;
    end
    step();
    step();
    rstn = 1'b1;

    // Directed sequence from reset
    for (int en = 1; en <= 95; en++) begin
      rdy_v[0] = (en == 50) ? 2'b10 : 2'b11;
      rdy_v[1] = (en <= 50) ? 2'b00 : 2'b11;
      rdy_v[2] = (en <= 30) ? 2'b01 : ((en == 85) ? 2'b10 : 2'b11);
      rdy_v[3] = 2'b11;
      restart_v[0] = 1'b0;
      restart_v[1] = (en == 80);
      restart_v[2] = (en == 40);
      restart_v[3] = 1'b0;
      step();
      case (en)
        20: begin
          check("d0_edge20", act[0], 5'b111_0_0);
          check("d3_edge20", act[3], 5'b001_0_0);
        end
        21: begin
          check("d0_edge21_rst0", act[0], 5'b110_0_0);
          check("d3_edge21_done", act[3], 5'b000_1_0);
        end
        30: check("d0_edge30", act[0], 5'b110_0_0);
        31: check("d0_edge31_rst1", act[0], 5'b100_0_0);
        35: check("d1_edge35_no_timeout", act[1], 5'b111_0_0);
        36: begin
          check("d1_edge36_timeout", act[1], 5'b111_0_1);
          check("d2_edge36_held", act[2], 5'b111_0_0);
        end
        37: check("d2_edge37_rst0", act[2], 5'b110_0_0);
        40: begin
          check("d0_edge40", act[0], 5'b100_0_0);
          check("d2_restart_in_release", act[2], 5'b111_0_0);
        end
        41: check("d0_edge41_done", act[0], 5'b000_1_0);
        51: check("d0_edge51_run", act[0], 5'b000_1_0);
        52: check("d0_loss_reassert", act[0], 5'b111_0_0);
        56: check("d1_edge56", act[1], 5'b111_0_1);
        57: check("d1_release_after_timeout", act[1], 5'b110_0_1);
        60: check("d2_edge60", act[2], 5'b111_0_0);
        61: check("d2_replay_rst0", act[2], 5'b110_0_0);
        67: check("d1_edge67_rst1", act[1], 5'b100_0_1);
        72: check("d0_edge72", act[0], 5'b111_0_0);
        73: check("d0_replay_rst0", act[0], 5'b110_0_0);
        80: check("d1_restart_clears_timeout", act[1], 5'b111_0_0);
        81: check("d2_replay_done", act[2], 5'b000_1_0);
        90: check("d2_loss_ignored", act[2], 5'b000_1_0);
        92: check("d0_edge92", act[0], 5'b100_0_0);
        93: check("d0_replay_done", act[0], 5'b000_1_0);
        default: ;
      endcase
    end

    // Randomised ready outages and restart pulses
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) begin
        if (outage[i] > 0) begin
          outage[i]--;
          rdy_v[i] = 2'($urandom_range(0, 2));
        end else if ($urandom_range(0, 99) == 0) begin
          outage[i] = $urandom_range(1, 40);
          rdy_v[i]  = 2'($urandom_range(0, 2));
        end else begin
          rdy_v[i] = 2'b11;
        end
        restart_v[i] = ($urandom_range(0, 249) == 0);
      end
      step();
    end

    // Asynchronous reset in the middle of the release phase
    rstn = 1'b0;
    for (int i = 0; i < NI; i++) begin
      restart_v[i] = 1'b0;
      rdy_v[i]     = 2'b11;
    end
    step();
    rstn = 1'b1;
    for (int en = 1; en <= 25; en++) step();
    check("d0_mid_release", act[0], 5'b110_0_0);
    check("d3_mid_release", act[3], 5'b000_1_0);
    #3;
    rstn = 1'b0;
    #1;
    check("d0_async_reset", act[0], 5'b111_0_0);
    check("d1_async_reset", act[1], 5'b111_0_0);
    check("d2_async_reset", act[2], 5'b111_0_0);
    check("d3_async_reset", act[3], 5'b001_0_0);
    step();
    step();
    rstn = 1'b1;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
